seq_detect_param: RTL and testbench

Parametrised, runtime-programmable serial bit-sequence detector. It is the successor to the team's fixed 7-bit Mealy detector. Pattern, length and overlap mode are loadable at run time, input is qualified by a valid strobe, and a saturating match counter is included. It sits on a serial bitstream path and drives a registered one-cycle match pulse plus a match count to downstream control logic.

---
 rtl/seq_detect_param_if.sv | 31 +++
 rtl/seq_detect_param.sv | 116 +++++++++++
 tb/tb_seq_detect_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Purpose: stream, configuration and result signals of seq_detect_param.
// master: drives serial data, configuration and counter clear; samples results.
// slave : the detector; samples inputs and drives out / match_count / cfg_err.
// MAX_LEN and CNT_W must match the parameters of the attached detector.
interface seq_detect_param_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  out, match_count, cfg_err
  );

  modport slave (
    input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output out, match_count, cfg_err
  );
endinterface

// File: rtl/seq_detect_param.sv
// Purpose: runtime-programmable serial bit-sequence detector with saturating
// match counter.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - seq_detect_param_if.slave:
//         in/in_valid          qualified serial bit
//         cfg_load/cfg_pattern/cfg_len/cfg_overlap  configuration load
//         cnt_clr              synchronous clear of match_count
//         out                  registered one-cycle match pulse
//         match_count          saturating match count
//         cfg_err              registered pulse on rejected configuration
module seq_detect_param #(
  parameter int unsigned       MAX_LEN     = 8,
  parameter int unsigned       DEF_LEN     = 7,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0110_0111),
  parameter bit                DEF_OVERLAP = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_param_if.slave  bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q,  out_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               err_q,  err_d;

  logic [MAX_LEN-1:0] mask_c;
  logic [MAX_LEN-1:0] hist_n_c;
  logic [LEN_W-1:0]   fill_n_c;
  logic               cfg_ok_c;
  logic               match_c;

  // Datapath helpers: active-length mask, shifted history, match decision
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(len_q));
    end
    hist_n_c = {hist_q[MAX_LEN-2:0], bus.in};
    fill_n_c = (32'(fill_q) >= MAX_LEN) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
    cfg_ok_c = (bus.cfg_len != '0) && (32'(bus.cfg_len) <= MAX_LEN);
    // Bits above len are masked off on both sides so stale history never matters
    match_c  = bus.in_valid && !bus.cfg_load && (fill_n_c >= len_q) &&
               ((hist_n_c & mask_c) == (pat_q & mask_c));
  end

  // Next-state logic: cfg_load beats in_valid; counter clear is independent
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    err_d  = 1'b0;

    if (bus.cfg_load) begin
      if (cfg_ok_c) begin
        pat_d = bus.cfg_pattern;
        len_d = bus.cfg_len;
        ovl_d = bus.cfg_overlap;
      end else begin
        err_d = 1'b1;
      end
      hist_d = '0;
      fill_d = '0;
    end else if (bus.in_valid) begin
      hist_d = hist_n_c;
      out_d  = match_c;
      // Non-overlapping mode restarts the fill count so matched bits are not reused
      fill_d = (match_c && !ovl_q) ? '0 : fill_n_c;
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Purpose: scoreboard bench for seq_detect_param (CNT_W=2 to reach saturation).
// The driver pushes one expected {out, match_count, cfg_err} per driven cycle;
// a monitor pops and compares shortly after each rising edge.
module tb_seq_detect_param;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int   id;
    logic o;
    int   cnt;
    logic err;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   step_id = 0;
  int   cnt_m   = 0;

  task automatic chk(input int id, input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL step%0d %s: got %0d want %0d", id, what, got, want);
    end
  endtask

  // Monitor: compare the entry queued for the edge that just happened
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.id, "out",         int'(bus.out),         int'(e.o));
        chk(e.id, "match_count", int'(bus.match_count), e.cnt);
        chk(e.id, "cfg_err",     int'(bus.cfg_err),     int'(e.err));
      end
    end
  end

  task automatic drive(input logic b, input logic v, input logic ld, input logic clr,
                       input logic [MAX_LEN-1:0] p, input int len, input logic ov,
                       input logic eo, input int ec, input logic ee);
    exp_t e;
    @(negedge clk);
    bus.in          = b;
    bus.in_valid    = v;
    bus.cfg_load    = ld;
    bus.cnt_clr     = clr;
    bus.cfg_pattern = p;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ov;
    e.id = step_id; e.o = eo; e.cnt = ec; e.err = ee;
    q.push_back(e);
    step_id++;
  endtask

  task automatic bit_(input logic b, input logic eo);
    drive(b, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0, eo, cnt_m, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, cnt_m, 1'b0);
  endtask

  task automatic clr();
    cnt_m = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Load with in_valid=1, in=1 to confirm the bit is ignored on a load cycle
  task automatic load(input logic [MAX_LEN-1:0] p, input int len, input logic ov, input logic ee);
    drive(1'b1, 1'b1, 1'b1, 1'b0, p, len, ov, 1'b0, cnt_m, ee);
  endtask

  // bits/outs listed first-bit-first in the top n bits; cnt_m saturates at 3
  task automatic stream(input logic [15:0] bits, input logic [15:0] outs, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (outs[i] && cnt_m < 3) cnt_m++;
      bit_(bits[i], outs[i]);
    end
  endtask

  initial begin
    bus.in = 1'b0; bus.in_valid = 1'b0; bus.cfg_load = 1'b0; bus.cnt_clr = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk(-1, "rst out",   int'(bus.out),         0);
    chk(-1, "rst count", int'(bus.match_count), 0);
    chk(-1, "rst err",   int'(bus.cfg_err),     0);
    rst = 1'b1;

    // Default pattern 1100111
    stream(16'b1100111, 16'b0000001, 7);
    clr();

    // 1011 overlapping, then non-overlapping
    load(8'b0000_1011, 4, 1'b1, 1'b0);
    stream(16'b1011011, 16'b0001001, 7);
    clr();
    load(8'b0000_1011, 4, 1'b0, 1'b0);
    stream(16'b1011011, 16'b0001000, 7);
    clr();

    // Stalls between bits 3 and 4
    load(8'b0110_0111, 7, 1'b1, 1'b0);
    stream(16'b110, 16'b000, 3);
    idle(); idle(); idle();
    stream(16'b0111, 16'b0001, 4);
    clr();

    // Rejected loads discard the partial match but keep config
    stream(16'b1100, 16'b0000, 4);
    load(8'hFF, 0, 1'b0, 1'b1);
    load(8'hFF, 9, 1'b0, 1'b1);
    idle();
    stream(16'b111, 16'b000, 3);
    stream(16'b1100111, 16'b0000001, 7);
    clr();

    // len=1 back-to-back matches, saturation, clear beats increment
    load(8'b0000_0001, 1, 1'b1, 1'b0);
    stream(16'b11111, 16'b11111, 5);
    cnt_m = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 0, 1'b0, 1'b1, 0, 1'b0);
    bit_(1'b0, 1'b0);

    // Full-width pattern (len = MAX_LEN)
    load(8'b1010_0101, 8, 1'b1, 1'b0);
    stream(16'b10100101, 16'b00000001, 8);

    // Asynchronous reset mid-cycle restores default config and clears count
    stream(16'b11001, 16'b00000, 5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk(-2, "async rst out",   int'(bus.out),         0);
    chk(-2, "async rst count", int'(bus.match_count), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt_m = 0;
    stream(16'b11, 16'b00, 2);
    stream(16'b1100111, 16'b0000001, 7);

    // Drain, bounded
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(-3, "scoreboard drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
